// File: rtl/store_queue_pkg.sv
// Shared store-queue types, depth constant and the ROB age comparison.
package store_queue_pkg;

    localparam int ROB_WIDTH = 5;
    localparam int SQ_DEPTH  = 4;

    typedef logic [ROB_WIDTH:0] robid_t;

    typedef struct packed {
        logic        valid;
        logic        committed;
        robid_t      robid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } sq_entry_t;

    // a is younger than b; the MSB is the ROB wrap bit.
    function automatic logic robid_younger(input robid_t a, input robid_t b);
        return a[ROB_WIDTH] ^ b[ROB_WIDTH] ^ (a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/sq_fwd_match.sv
// Youngest-match word-address selector over the live window [head, tail).
module sq_fwd_match #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [29:0]      word_addr_i [DEPTH],
    input  logic [31:0]      data_i      [DEPTH],
    input  logic [PW-1:0]    head_i,
    input  logic [PW-1:0]    tail_i,
    input  logic [29:0]      load_word_i,
    output logic             hit_o,
    output logic [31:0]      data_o
);
    localparam int AW = PW - 1;

    logic [PW-1:0] span;
    logic [AW-1:0] idx;

    // Walk oldest to youngest so the last hit is the youngest store.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        span   = tail_i - head_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i[AW-1:0] + AW'(k);
            if (PW'(k) < span && valid_i[idx] && word_addr_i[idx] == load_word_i) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// In-order circular store buffer: alloc from LSU, ROB commit, drain to dmem,
// word-granular youngest-match load forwarding, squash of younger stores on flush.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int DEPTH       = SQ_DEPTH,
    parameter bit PROTO_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_valid,
    input  logic [ROB_WIDTH:0] flush_robid,
    input  logic               lsuint2sq_instr0_valid,
    input  logic [ROB_WIDTH:0] lsuint2sq_instr0_robid,
    input  logic [31:0]        lsuint2sq_wb_addr,
    input  logic [31:0]        lsuint2sq_wb_data,
    input  logic [31:0]        lsuint2sq_instr0_pc,
    output logic [1:0]         sq_left,
    input  logic [31:0]        load_addr,
    output logic               sq_fwd_valid,
    output logic [31:0]        sq_fwd_data,
    input  logic               rob_commit_valid,
    input  logic [ROB_WIDTH:0] rob_commit_robid,
    output logic               mem_write_req,
    output logic [31:0]        mem_write_addr,
    output logic [31:0]        mem_write_data,
    output logic [31:0]        mem_write_pc,
    input  logic               mem_write_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    sq_entry_t     entries_q [DEPTH];
    sq_entry_t     entries_d [DEPTH];
    logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [PW-1:0] count, free_cnt, span;
    logic [AW-1:0] idx;
    logic          full, do_alloc, do_drain, found;

    logic [DEPTH-1:0] ent_vld;
    logic [29:0]      ent_word [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    wire              unused_load_lo = ^load_addr[1:0];

    assign count    = tail_q - head_q;
    assign full     = (count == PW'(DEPTH));
    assign free_cnt = PW'(DEPTH) - count;
    assign sq_left  = (free_cnt >= PW'(3)) ? 2'd3 : free_cnt[1:0];

    assign mem_write_req  = entries_q[head_q[AW-1:0]].valid & entries_q[head_q[AW-1:0]].committed;
    assign mem_write_addr = entries_q[head_q[AW-1:0]].addr;
    assign mem_write_data = entries_q[head_q[AW-1:0]].data;
    assign mem_write_pc   = entries_q[head_q[AW-1:0]].pc;

    assign do_alloc = lsuint2sq_instr0_valid & ~full & ~flush_valid;
    assign do_drain = mem_write_req & mem_write_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld[i]  = entries_q[i].valid;
            ent_word[i] = entries_q[i].addr[31:2];
            ent_data[i] = entries_q[i].data;
        end
    end

    sq_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
        .valid_i     (ent_vld),
        .word_addr_i (ent_word),
        .data_i      (ent_data),
        .head_i      (head_q),
        .tail_i      (tail_q),
        .load_word_i (load_addr[31:2]),
        .hit_o       (sq_fwd_valid),
        .data_o      (sq_fwd_data)
    );

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        cmt_d     = cmt_q;
        tail_d    = tail_q;
        span      = '0;
        idx       = '0;
        found     = 1'b0;
        if (do_drain) begin
            entries_d[head_q[AW-1:0]] = '0;
            head_d = head_q + PW'(1);
        end
        if (rob_commit_valid) begin
            entries_d[cmt_q[AW-1:0]].committed = 1'b1;
            cmt_d = cmt_q + PW'(1);
        end
        if (do_alloc) begin
            entries_d[tail_q[AW-1:0]] = '{valid: 1'b1, committed: 1'b0,
                                          robid: lsuint2sq_instr0_robid,
                                          addr:  lsuint2sq_wb_addr,
                                          data:  lsuint2sq_wb_data,
                                          pc:    lsuint2sq_instr0_pc};
            tail_d = tail_q + PW'(1);
        end
        // Scan starts after this cycle's commit so a just-committed store survives.
        if (flush_valid) begin
            span = tail_q - cmt_d;
            for (int k = 0; k < DEPTH; k++) begin
                idx = cmt_d[AW-1:0] + AW'(k);
                if (PW'(k) < span && entries_q[idx].valid && !entries_q[idx].committed &&
                    robid_younger(entries_q[idx].robid, flush_robid)) begin
                    if (!found) tail_d = cmt_d + PW'(k);
                    found          = 1'b1;
                    entries_d[idx] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            cmt_q     <= cmt_d;
            tail_q    <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (PROTO_CHECK && !reset) begin
            assert (!(lsuint2sq_instr0_valid && full && !flush_valid));
            if (rob_commit_valid)
                assert (entries_q[cmt_q[AW-1:0]].valid &&
                        entries_q[cmt_q[AW-1:0]].robid == rob_commit_robid);
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: occupancy, forwarding, commit/drain, flush, wrap.
module tb_store_queue;
    import store_queue_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush_valid;
    logic [ROB_WIDTH:0] flush_robid;
    logic               lsuint2sq_instr0_valid;
    logic [ROB_WIDTH:0] lsuint2sq_instr0_robid;
    logic [31:0]        lsuint2sq_wb_addr, lsuint2sq_wb_data, lsuint2sq_instr0_pc;
    logic [1:0]         sq_left;
    logic [31:0]        load_addr;
    logic               sq_fwd_valid;
    logic [31:0]        sq_fwd_data;
    logic               rob_commit_valid;
    logic [ROB_WIDTH:0] rob_commit_robid;
    logic               mem_write_req;
    logic [31:0]        mem_write_addr, mem_write_data, mem_write_pc;
    logic               mem_write_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Protocol assertions are off because the bench deliberately allocates into a full queue.
    store_queue #(.DEPTH(4), .PROTO_CHECK(1'b0)) dut (
        .clk(clk), .reset(reset),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .lsuint2sq_instr0_valid(lsuint2sq_instr0_valid),
        .lsuint2sq_instr0_robid(lsuint2sq_instr0_robid),
        .lsuint2sq_wb_addr(lsuint2sq_wb_addr),
        .lsuint2sq_wb_data(lsuint2sq_wb_data),
        .lsuint2sq_instr0_pc(lsuint2sq_instr0_pc),
        .sq_left(sq_left),
        .load_addr(load_addr),
        .sq_fwd_valid(sq_fwd_valid), .sq_fwd_data(sq_fwd_data),
        .rob_commit_valid(rob_commit_valid), .rob_commit_robid(rob_commit_robid),
        .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write_pc(mem_write_pc),
        .mem_write_ready(mem_write_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then return inputs to idle 1ns after the edge.
    task automatic next();
        @(posedge clk);
        #1;
        flush_valid            = 1'b0;
        flush_robid            = '0;
        lsuint2sq_instr0_valid = 1'b0;
        rob_commit_valid       = 1'b0;
        mem_write_ready        = 1'b0;
    endtask

    task automatic alloc(input int rid, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        lsuint2sq_instr0_valid = 1'b1;
        lsuint2sq_instr0_robid = ROB_WIDTH'(rid);
        lsuint2sq_wb_addr      = a;
        lsuint2sq_wb_data      = d;
        lsuint2sq_instr0_pc    = p;
    endtask

    task automatic commit(input int rid);
        rob_commit_valid = 1'b1;
        rob_commit_robid = ROB_WIDTH'(rid);
    endtask

    initial begin
        int cnt;
        int exp_left;
        reset = 1'b1;
        load_addr = '0;
        lsuint2sq_instr0_robid = '0;
        lsuint2sq_wb_addr = '0;
        lsuint2sq_wb_data = '0;
        lsuint2sq_instr0_pc = '0;
        rob_commit_robid = '0;
        next();
        next();
        reset = 1'b0;
        #1;
        chk("rst_left", 32'(sq_left), 3);
        chk("rst_fwdv", 32'(sq_fwd_valid), 0);
        chk("rst_fwdd", sq_fwd_data, 0);
        chk("rst_req", 32'(mem_write_req), 0);
        chk("rst_addr", mem_write_addr, 0);
        chk("rst_data", mem_write_data, 0);
        chk("rst_pc", mem_write_pc, 0);

        // Fill: sq_left 3,3,2,1 before each alloc, 0 when full.
        for (int i = 0; i < 4; i++) begin
            alloc(i + 1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 32'h8000 + 32'(4 * i));
            #1;
            chk("fill_left", 32'(sq_left), (4 - i > 3) ? 3 : 4 - i);
            next();
        end
        alloc(5, 32'h110, 32'hDEAD, 32'h8010);
        #1;
        chk("full_left", 32'(sq_left), 0);
        next();
        load_addr = 32'h110;
        #1;
        chk("drop_fwdv", 32'(sq_fwd_valid), 0);
        chk("drop_left", 32'(sq_left), 0);
        load_addr = 32'h10A;
        #1;
        chk("fwd_old_v", 32'(sq_fwd_valid), 1);
        chk("fwd_old_d", sq_fwd_data, 32'h1002);
        chk("nocmt_req", 32'(mem_write_req), 0);

        // Commit robid 1 and stall dmem for three cycles.
        next();
        commit(1);
        next();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_req", 32'(mem_write_req), 1);
            chk("stall_addr", mem_write_addr, 32'h100);
            next();
        end
        mem_write_ready = 1'b1;
        #1;
        chk("drain_data", mem_write_data, 32'h1000);
        chk("drain_pc", mem_write_pc, 32'h8000);
        chk("drain_left0", 32'(sq_left), 0);
        next();
        #1;
        chk("drain_left1", 32'(sq_left), 1);
        chk("drain_req0", 32'(mem_write_req), 0);

        // Drain robid 2, commit robid 3, then two same-word allocs that wrap.
        commit(2);
        next();
        mem_write_ready = 1'b1;
        #1;
        chk("d2_addr", mem_write_addr, 32'h104);
        next();
        commit(3);
        next();
        alloc(5, 32'h200, 32'hAAAA, 32'h9000);
        next();
        alloc(6, 32'h200, 32'hBBBB, 32'h9004);
        next();
        load_addr = 32'h202;
        #1;
        chk("full2_left", 32'(sq_left), 0);
        chk("young_v", 32'(sq_fwd_valid), 1);
        chk("young_d", sq_fwd_data, 32'hBBBB);
        load_addr = 32'h204;
        #1;
        chk("miss_v", 32'(sq_fwd_valid), 0);
        chk("miss_d", sq_fwd_data, 0);
        load_addr = 32'h10C;
        #1;
        chk("r4_d", sq_fwd_data, 32'h1003);
        chk("r3_req_addr", mem_write_addr, 32'h108);

        // Flush at robid 4: 5 and 6 squashed, forwarding is pre-flush this cycle.
        flush_valid = 1'b1;
        flush_robid = 6'd4;
        load_addr = 32'h202;
        #1;
        chk("flush_fwd_d", sq_fwd_data, 32'hBBBB);
        next();
        #1;
        chk("pf_left", 32'(sq_left), 2);
        chk("pf_fwdv", 32'(sq_fwd_valid), 0);
        load_addr = 32'h10C;
        #1;
        chk("pf_keep_v", 32'(sq_fwd_valid), 1);
        chk("pf_req_addr", mem_write_addr, 32'h108);
        mem_write_ready = 1'b1;
        next();
        #1;
        chk("pf_drain_req", 32'(mem_write_req), 0);
        chk("pf_drain_left", 32'(sq_left), 3);

        // Flush in the same cycle robid 5 commits: 5 kept, 6 squashed.
        alloc(5, 32'h300, 32'h5555, 32'h9100);
        next();
        alloc(6, 32'h304, 32'h6666, 32'h9104);
        next();
        commit(4);
        next();
        commit(5);
        flush_valid = 1'b1;
        flush_robid = 6'd4;
        next();
        load_addr = 32'h304;
        #1;
        chk("fc_left", 32'(sq_left), 2);
        chk("fc_sq6_v", 32'(sq_fwd_valid), 0);
        load_addr = 32'h300;
        #1;
        chk("fc_keep5_d", sq_fwd_data, 32'h5555);
        chk("fc_req_addr", mem_write_addr, 32'h10C);
        mem_write_ready = 1'b1;
        next();
        mem_write_ready = 1'b1;
        #1;
        chk("fc_r5_req", 32'(mem_write_req), 1);
        chk("fc_r5_addr", mem_write_addr, 32'h300);
        chk("fc_r5_pc", mem_write_pc, 32'h9100);
        next();
        #1;
        chk("fc_empty_req", 32'(mem_write_req), 0);
        chk("fc_empty_left", 32'(sq_left), 3);

        // Streaming 10 stores through the wrapped ring with ready held high.
        for (int c = 0; c < 12; c++) begin
            if (c < 10) alloc(10 + c, 32'h400 + 32'(4 * c), 32'hC000 + 32'(c), 32'hA000 + 32'(c));
            if (c >= 1 && c <= 10) commit(10 + c - 1);
            mem_write_ready = 1'b1;
            #1;
            cnt = ((c < 10) ? c : 10) - ((c >= 2) ? c - 2 : 0);
            exp_left = (4 - cnt > 3) ? 3 : 4 - cnt;
            chk("wrap_left", 32'(sq_left), 32'(exp_left));
            if (c >= 2) begin
                chk("wrap_req", 32'(mem_write_req), 1);
                chk("wrap_addr", mem_write_addr, 32'h400 + 32'(4 * (c - 2)));
                chk("wrap_data", mem_write_data, 32'hC000 + 32'(c - 2));
            end
            next();
        end
        #1;
        chk("wrap_end_req", 32'(mem_write_req), 0);
        chk("wrap_end_left", 32'(sq_left), 3);

        // Reset while a committed store waits for dmem.
        alloc(20, 32'h500, 32'h77, 32'hB000);
        next();
        commit(20);
        next();
        #1;
        chk("mr_req_pre", 32'(mem_write_req), 1);
        reset = 1'b1;
        next();
        #1;
        chk("mr_req", 32'(mem_write_req), 0);
        chk("mr_addr", mem_write_addr, 0);
        chk("mr_left", 32'(sq_left), 3);
        reset = 1'b0;
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
